// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  function automatic int cnt_width(input int width_a);
    return (width_a > 1) ? $clog2(width_a) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module div_step #(
  parameter int WIDTH_B = 4
) (
  input  logic [WIDTH_B:0]   pr,
  input  logic               din,
  input  logic [WIDTH_B-1:0] divisor,
  output logic [WIDTH_B:0]   pr_next,
  output logic               qbit
);

  logic [WIDTH_B:0] shifted;
  logic [WIDTH_B:0] dext;
  logic             fits;

  // The top partial-remainder bit is always zero after a restoring step; folding it
  // into the fit test keeps the step correct even if that ever stopped being true.
  always_comb begin
    shifted = {pr[WIDTH_B-1:0], din};
    dext    = {1'b0, divisor};
    fits    = pr[WIDTH_B] | (shifted >= dext);
    if (fits) begin
      pr_next = shifted - dext;
      qbit    = 1'b1;
    end else begin
      pr_next = shifted;
      qbit    = 1'b0;
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider producing one quotient bit per clock,
// with valid/ready handshakes on both the operand and result sides.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] a,
  input  logic [WIDTH_B-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_A-1:0] q,
  output logic [WIDTH_B-1:0] r,
  output logic               div_by_zero
);

  localparam int             CNT_W    = cnt_width(WIDTH_A);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH_A - 1);

  div_state_t         state;
  div_state_t         state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH_A-1:0] qsr;
  logic [WIDTH_B:0]   pr;
  logic [WIDTH_B-1:0] divisor;
  logic [WIDTH_A-1:0] q_reg;
  logic [WIDTH_B-1:0] r_reg;
  logic               dbz_reg;

  logic [WIDTH_B:0]   pr_next;
  logic               qbit;
  logic               accept;
  logic               b_zero;
  logic [WIDTH_A-1:0] qsr_next;

  div_step #(.WIDTH_B(WIDTH_B)) u_step (
    .pr      (pr),
    .din     (qsr[WIDTH_A-1]),
    .divisor (divisor),
    .pr_next (pr_next),
    .qbit    (qbit)
  );

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready;
  assign b_zero      = (b == '0);
  assign qsr_next    = {qsr[WIDTH_A-2:0], qbit};
  assign q           = q_reg;
  assign r           = r_reg;
  assign div_by_zero = dbz_reg;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = b_zero ? DONE : CALC;
      CALC: if (cnt == '0) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Iteration datapath: operands are captured on accept, then stepped MSB-first.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      qsr     <= '0;
      pr      <= '0;
      divisor <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !b_zero) begin
            qsr     <= a;
            divisor <= b;
            pr      <= '0;
            cnt     <= CNT_LOAD;
          end
        end
        CALC: begin
          qsr <= qsr_next;
          pr  <= pr_next;
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers only change when a result is produced, so they hold during stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg   <= '0;
      r_reg   <= '0;
      dbz_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && b_zero) begin
            q_reg   <= '1;
            r_reg   <= a[WIDTH_B-1:0];
            dbz_reg <= 1'b1;
          end
        end
        CALC: begin
          if (cnt == '0) begin
            q_reg   <= qsr_next;
            r_reg   <= pr_next[WIDTH_B-1:0];
            dbz_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: directed corner cases followed by
// randomized back-to-back traffic with random result stalls.
module tb_seq_restoring_divider;

  localparam int WA = 8;
  localparam int WB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [WA-1:0] a;
  logic [WB-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [WA-1:0] q;
  logic [WB-1:0] r;
  logic          div_by_zero;

  typedef struct {
    logic [WA-1:0] a;
    logic [WB-1:0] b;
  } op_t;

  op_t sb[$];
  int  checks   = 0;
  int  failures = 0;
  bit  rand_ready = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s", name);
  endtask

  // Monitor: inputs only change 1 time unit after a rising edge, so the values seen
  // on the falling edge are exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      checkOutput("valid_ready_exclusive", 32'(out_valid && in_ready), 32'd0);
      if (in_valid && in_ready) sb.push_back('{a: a, b: b});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          failNow("unexpected_result_with_empty_scoreboard");
        end else begin
          op_t           op;
          logic [WA-1:0] eq;
          logic [WB-1:0] er;
          op = sb.pop_front();
          if (op.b == 0) begin
            eq = '1;
            er = op.a[WB-1:0];
          end else begin
            eq = WA'(int'(op.a) / int'(op.b));
            er = WB'(int'(op.a) % int'(op.b));
          end
          checkOutput("sb_q", 32'(q), 32'(eq));
          checkOutput("sb_r", 32'(r), 32'(er));
          checkOutput("sb_dbz", 32'(div_by_zero), 32'(op.b == 0));
          if (op.b != 0) begin
            checkOutput("inv_a_eq_qb_plus_r", int'(q) * int'(op.b) + int'(r), 32'(op.a));
            checkOutput("inv_r_lt_b", 32'(r < op.b), 32'd1);
          end
        end
      end
    end
  end

  // Drives one operand pair, returns once it has been accepted (or the wait times out).
  task automatic applyStimulus(input logic [WA-1:0] ai, input logic [WB-1:0] bi, output bit ok);
    int n;
    ok = 0;
    in_valid = 1'b1;
    a = ai;
    b = bi;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      failNow("accept_timeout");
    end else begin
      ok = 1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = WA'($urandom);
    b = WB'($urandom);
  endtask

  // Counts rising edges after the accepting edge until out_valid appears.
  task automatic waitResult(output int edges);
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!out_valid) failNow("result_timeout");
  endtask

  task automatic runDirected(input logic [WA-1:0] ai, input logic [WB-1:0] bi,
                             input logic [WA-1:0] eq, input logic [WB-1:0] er,
                             input logic edbz, input int elat, input string tag);
    bit ok;
    int lat;
    applyStimulus(ai, bi, ok);
    if (ok) begin
      waitResult(lat);
      checkOutput({tag, "_latency"}, 32'(lat), 32'(elat));
      checkOutput({tag, "_q"}, 32'(q), 32'(eq));
      checkOutput({tag, "_r"}, 32'(r), 32'(er));
      checkOutput({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
      if (out_ready) begin
        @(posedge clk);
        #1;
        checkOutput({tag, "_in_ready_after_consume"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_out_valid_after_consume"}, 32'(out_valid), 32'd0);
      end
    end
  endtask

  initial begin
    bit ok;
    int lat;
    int n;
    logic [WA-1:0] hq;
    logic [WB-1:0] hr;

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_q", 32'(q), 32'd0);
    checkOutput("reset_r", 32'(r), 32'd0);
    checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);

    // Non-zero divisors complete WA edges after the accepting edge; a zero divisor
    // is reported by the accepting edge itself.
    runDirected(8'd200, 4'd7,  8'd28,  4'd4, 1'b0, WA, "t1_200_7");
    runDirected(8'd255, 4'd1,  8'd255, 4'd0, 1'b0, WA, "t2_255_1");
    runDirected(8'd5,   4'd9,  8'd0,   4'd5, 1'b0, WA, "t2_5_9");
    runDirected(8'd0,   4'd15, 8'd0,   4'd0, 1'b0, WA, "t2_0_15");
    runDirected(8'd13,  4'd0,  8'hFF,  4'hD, 1'b1, 0,  "t3_dbz");

    out_ready = 1'b0;
    applyStimulus(8'd100, 4'd3, ok);
    if (ok) begin
      waitResult(lat);
      hq = q;
      hr = r;
      checkOutput("t4_q", 32'(hq), 32'd33);
      checkOutput("t4_r", 32'(hr), 32'd1);
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1;
        a = WA'($urandom);
        b = WB'($urandom);
        @(posedge clk);
        #1;
        checkOutput("t4_hold_q", 32'(q), 32'(hq));
        checkOutput("t4_hold_r", 32'(r), 32'(hr));
        checkOutput("t4_hold_valid", 32'(out_valid), 32'd1);
        checkOutput("t4_hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("t4_in_ready_after_consume", 32'(in_ready), 32'd1);
    end

    applyStimulus(8'd50, 4'd3, ok);
    if (ok) begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("t5_in_ready", 32'(in_ready), 32'd1);
      checkOutput("t5_out_valid", 32'(out_valid), 32'd0);
      checkOutput("t5_q", 32'(q), 32'd0);
      checkOutput("t5_r", 32'(r), 32'd0);
      runDirected(8'd9, 4'd2, 8'd4, 4'd1, 1'b0, WA, "t5_9_2");
    end

    rand_ready = 1;
    fork
      begin
        while (rand_ready) begin
          @(posedge clk);
          #1;
          if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(WA'($urandom), WB'($urandom_range(0, 15)), ok);
    end
    rand_ready = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
